// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm
//   Drives one LED with PWM in one of four modes: OFF, ON, BLINK or BREATHE.
//   BREATHE ramps the duty linearly up and down. BLINK toggles the duty between
//   0 and MAX. Both advance on ticks from the upstream divider.
//   Mode requests use a valid/ready handshake. A request takes effect only on a
//   PWM period boundary (pwm_cnt == MAX), so the LED never changes mid-period.
//   At most one tick is applied per period; extra ticks in the same period are
//   merged into that one advance.
//
//   Optional build macro: LED_BREATHE_GAMMA_EN
//     Defined:     the compare value is (duty*duty) >> PWM_BITS, held in a
//                  register. This gives a perceptually smoother fade and adds one
//                  cycle between a duty change and the compare. MAX maps to
//                  MAX-1. ON mode is not affected.
//     Not defined: the compare value is the duty itself.

module led_breathe_pwm #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [1:0]          mode,
    input  logic                mode_valid,
    output logic                mode_ready,
    output logic                led0,
    output logic [PWM_BITS-1:0] level,
    output logic                period_end
);

    localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    dir_t                dir_q, dir_d;
    mode_t               cur_mode_q, cur_mode_d;
    mode_t               pend_mode_q, pend_mode_d;
    logic                tick_pend_q, tick_pend_d;
    logic                mode_ready_q, mode_ready_d;
    logic                led0_q, led0_d;
    logic                period_end_q, period_end_d;

    logic                boundary;
    logic                accept;
    logic                pend_flag;
    logic                tick_seen;
    logic                entering_anim;
    logic [PWM_BITS:0]   duty_w;
    logic [PWM_BITS:0]   sum_w;
    logic [PWM_BITS:0]   diff_w;
    logic [PWM_BITS-1:0] cmp;

    // A boundary is the last cycle of a PWM period.
    assign boundary  = (pwm_cnt_q == MAX);
    assign accept    = mode_valid && mode_ready_q;
    // A request is waiting to be applied whenever ready is low.
    assign pend_flag = !mode_ready_q;
    // A tick arriving on the boundary cycle itself counts for this period.
    assign tick_seen = tick_pend_q || tick;
    assign entering_anim = (pend_mode_q == MODE_BLINK) || (pend_mode_q == MODE_BREATHE);

    // The ramp arithmetic uses one extra bit, so a step can never wrap.
    assign duty_w = {1'b0, duty_q};
    assign sum_w  = duty_w + STEP_W;
    assign diff_w = duty_w - STEP_W;

    // PWM counter: free-running from 0 to MAX, then wraps to 0.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // Register for the PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Handshake: capture the request and drop ready until the boundary applies it.
    always_comb begin
        mode_ready_d = mode_ready_q;
        pend_mode_d  = pend_mode_q;
        if (accept) begin
            mode_ready_d = 1'b0;
            pend_mode_d  = mode_t'(mode);
        end else if (boundary && pend_flag) begin
            mode_ready_d = 1'b1;
        end
    end

    // Registers for the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_ready_q <= 1'b1;
            pend_mode_q  <= MODE_OFF;
        end else begin
            mode_ready_q <= mode_ready_d;
            pend_mode_q  <= pend_mode_d;
        end
    end

    // Next-state logic for mode, duty, ramp direction and merged tick.
    // A pending mode change has priority over a tick at the boundary.
    always_comb begin
        cur_mode_d  = cur_mode_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        tick_pend_d = tick_pend_q || tick;
        if (boundary) begin
            if (pend_flag) begin
                cur_mode_d = pend_mode_q;
                duty_d     = '0;
                if (entering_anim) begin
                    // A new animation starts clean. A tick on this cycle is dropped.
                    dir_d       = DIR_UP;
                    tick_pend_d = 1'b0;
                end
            end else if (tick_seen) begin
                tick_pend_d = 1'b0;
                case (cur_mode_q)
                    MODE_BLINK: begin
                        duty_d = (duty_q == '0) ? MAX : '0;
                    end
                    MODE_BREATHE: begin
                        if (dir_q == DIR_UP) begin
                            if (sum_w >= MAX_W) begin
                                duty_d = MAX;
                                dir_d  = DIR_DOWN;
                            end else begin
                                duty_d = sum_w[PWM_BITS-1:0];
                            end
                        end else begin
                            if (duty_w <= STEP_W) begin
                                duty_d = '0;
                                dir_d  = DIR_UP;
                            end else begin
                                duty_d = diff_w[PWM_BITS-1:0];
                            end
                        end
                    end
                    default: begin
                        // OFF and ON ignore ticks.
                    end
                endcase
            end
        end
    end

    // State register for the breathe direction (UP/DOWN).
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end

    // Registers for mode, duty and the merged tick flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_mode_q  <= MODE_OFF;
            duty_q      <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            duty_q      <= duty_d;
            tick_pend_q <= tick_pend_d;
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;
    logic [PWM_BITS-1:0]   cmp_q;

    assign duty_sq = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};

    // Squared compare value, registered to break the multiplier path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q <= '0;
        end else begin
            cmp_q <= duty_sq[2*PWM_BITS-1:PWM_BITS];
        end
    end

    assign cmp = cmp_q;
`else
    assign cmp = duty_q;
`endif

    // LED compare. A duty of 0 gives constant low; MAX gives MAX high cycles per period.
    always_comb begin
        led0_d       = 1'b0;
        period_end_d = boundary;
        case (cur_mode_q)
            MODE_OFF: led0_d = 1'b0;
            MODE_ON:  led0_d = 1'b1;
            default:  led0_d = (pwm_cnt_q < cmp);
        endcase
    end

    // Output registers for the pin and the period strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            led0_q       <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            led0_q       <= led0_d;
            period_end_q <= period_end_d;
        end
    end

    assign led0       = led0_q;
    assign period_end = period_end_q;
    assign mode_ready = mode_ready_q;
    assign level      = duty_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Testbench for led_breathe_pwm, built with PWM_BITS=4 and STEP=4 (MAX=15,
// period of 16 clk). The expected duty levels are pushed into a queue when a
// mode request or tick is driven. They are popped and compared at each
// period_end strobe.
module tb_led_breathe_pwm;

    localparam int PWM_BITS = 4;
    localparam int STEP     = 4;
    localparam int PERIOD   = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic [1:0]          mode;
    logic                mode_valid;
    logic                mode_ready;
    logic                led0;
    logic [PWM_BITS-1:0] level;
    logic                period_end;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    led_breathe_pwm #(
        .PWM_BITS (PWM_BITS),
        .STEP     (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .led0       (led0),
        .level      (level),
        .period_end (period_end)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next sample where period_end is high (pwm_cnt == 0).
    task automatic wait_pe(input string name);
        int n;
        n = 0;
        step();
        while (period_end !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (period_end !== 1'b1) begin
            errors++;
            $display("FAIL %s: period_end not seen within 40 clk (got %b, want 1)", name, period_end);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; mode = 2'b00; mode_valid = 1'b0;
        repeat (3) step();
        checks += 4;
        if (led0 !== 1'b0)       begin errors++; $display("FAIL reset_led0: got %b want 0", led0); end
        if (level !== 4'd0)      begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        if (mode_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mode_ready); end
        if (period_end !== 1'b0) begin errors++; $display("FAIL reset_period_end: got %b want 0", period_end); end
        $display("reset: led0=%b level=%0d ready=%b period_end=%b", led0, level, mode_ready, period_end);
        rst = 1'b0;
    endtask

    task automatic test_breathe();
        int exp;
        int high;
        wait_pe("breathe_sync0");
        step(); step();
        checks++;
        if (mode_ready !== 1'b1) begin errors++; $display("FAIL breathe_ready_pre: got %b want 1", mode_ready); end
        mode = 2'b11; mode_valid = 1'b1;
        exp_q.push_back(0);
        step();
        mode_valid = 1'b0;
        checks++;
        if (mode_ready !== 1'b0) begin errors++; $display("FAIL breathe_ready_low: got %b want 0", mode_ready); end
        wait_pe("breathe_apply");
        checks++;
        if (mode_ready !== 1'b1) begin errors++; $display("FAIL breathe_ready_back: got %b want 1", mode_ready); end
        exp_q.push_back(4);  exp_q.push_back(8);  exp_q.push_back(12);
        exp_q.push_back(15); exp_q.push_back(11); exp_q.push_back(7);
        exp_q.push_back(3);  exp_q.push_back(0);  exp_q.push_back(4);
        for (int p = 0; p < 10; p++) begin
            exp = exp_q.pop_front();
            checks++;
            if (level !== PWM_BITS'(exp)) begin
                errors++; $display("FAIL breathe_level[%0d]: got %0d want %0d", p, level, exp);
            end
            high = 0;
            for (int i = 0; i < PERIOD; i++) begin
                if (led0 === 1'b1) high++;
                tick = (i == 5);
                step();
            end
            tick = 1'b0;
            checks += 2;
            if (period_end !== 1'b1) begin errors++; $display("FAIL breathe_period[%0d]: got %b want 1", p, period_end); end
            if (high != exp) begin errors++; $display("FAIL breathe_duty[%0d]: led0 high %0d clk want %0d", p, high, exp); end
            $display("breathe period %0d: level=%0d led0_high=%0d", p, exp, high);
        end
    endtask

    task automatic test_blink_merge();
        int exp;
        int high;
        step(); step();
        mode = 2'b10; mode_valid = 1'b1;
        exp_q.push_back(0);
        step();
        mode_valid = 1'b0;
        wait_pe("blink_apply");
        exp = exp_q.pop_front();
        checks++;
        if (level !== PWM_BITS'(exp)) begin errors++; $display("FAIL blink_enter: got %0d want %0d", level, exp); end
        $display("blink enter: level=%0d", level);
        // Three ticks in one period merge into a single toggle.
        exp_q.push_back(15);
        for (int i = 0; i < PERIOD; i++) begin
            tick = (i == 3) || (i == 6) || (i == 9);
            step();
        end
        tick = 1'b0;
        exp = exp_q.pop_front();
        checks += 2;
        if (period_end !== 1'b1) begin errors++; $display("FAIL blink_period: got %b want 1", period_end); end
        if (level !== PWM_BITS'(exp)) begin errors++; $display("FAIL blink_merge: got %0d want %0d", level, exp); end
        $display("blink 3 ticks: level=%0d", level);
        // A period with no ticks leaves the level unchanged.
        exp_q.push_back(15);
        high = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (led0 === 1'b1) high++;
            step();
        end
        exp = exp_q.pop_front();
        checks += 2;
        if (level !== PWM_BITS'(exp)) begin errors++; $display("FAIL blink_hold: got %0d want %0d", level, exp); end
        if (high != 15) begin errors++; $display("FAIL blink_duty_max: led0 high %0d clk want 15", high); end
        $display("blink no tick: level=%0d led0_high=%0d", level, high);
    endtask

    task automatic test_reset_mid();
        int high;
        repeat (5) step();
        checks++;
        if (led0 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_led0: got %b want 1", led0); end
        rst = 1'b1;
        step();
        checks += 4;
        if (led0 !== 1'b0)       begin errors++; $display("FAIL rstmid_led0: got %b want 0", led0); end
        if (level !== 4'd0)      begin errors++; $display("FAIL rstmid_level: got %0d want 0", level); end
        if (mode_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", mode_ready); end
        if (period_end !== 1'b0) begin errors++; $display("FAIL rstmid_period_end: got %b want 0", period_end); end
        step(); step();
        rst = 1'b0;
        high = 0;
        for (int i = 0; i < 20; i++) begin
            if (led0 !== 1'b0) high++;
            step();
        end
        checks++;
        if (high != 0) begin errors++; $display("FAIL rstmid_off: led0 high %0d clk want 0", high); end
        $display("reset mid-period: led0=%b level=%0d off_high=%0d", led0, level, high);
    endtask

    task automatic test_back_to_back();
        int exp;
        int high;
        wait_pe("b2b_sync");
        step(); step();
        mode = 2'b10; mode_valid = 1'b1;
        exp_q.push_back(0);
        step();
        mode_valid = 1'b0;
        wait_pe("b2b_blink");
        exp = exp_q.pop_front();
        checks++;
        if (level !== PWM_BITS'(exp)) begin errors++; $display("FAIL b2b_blink_enter: got %0d want %0d", level, exp); end
        repeat (PERIOD - 1) step();
        // This is the boundary cycle: a tick and an ON request arrive together.
        checks++;
        if (mode_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_pre: got %b want 1", mode_ready); end
        tick = 1'b1; mode = 2'b01; mode_valid = 1'b1;
        exp_q.push_back(15);
        exp_q.push_back(0);
        step();
        tick = 1'b0; mode_valid = 1'b0;
        exp = exp_q.pop_front();
        checks += 3;
        if (period_end !== 1'b1) begin errors++; $display("FAIL b2b_period: got %b want 1", period_end); end
        if (level !== PWM_BITS'(exp)) begin errors++; $display("FAIL b2b_tick_now: got %0d want %0d", level, exp); end
        if (mode_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", mode_ready); end
        $display("boundary accept+tick: level=%0d ready=%b", level, mode_ready);
        // A request while ready is low must be ignored.
        step(); step();
        mode = 2'b00; mode_valid = 1'b1;
        step();
        mode_valid = 1'b0;
        wait_pe("b2b_on_apply");
        exp = exp_q.pop_front();
        checks += 2;
        if (level !== PWM_BITS'(exp)) begin errors++; $display("FAIL b2b_on_level: got %0d want %0d", level, exp); end
        if (mode_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b want 1", mode_ready); end
        step();
        high = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (led0 === 1'b1) high++;
            step();
        end
        checks++;
        if (high != PERIOD) begin errors++; $display("FAIL b2b_on_led0: led0 high %0d clk want %0d", high, PERIOD); end
        $display("ON applied: level=%0d led0_high=%0d", level, high);
    endtask

    initial begin
        test_reset();
        test_breathe();
        test_blink_merge();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
